// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
//   fetch_state_t    : fetch controller states
//   NOP_WORD         : bubble encoding written into IF/ID
//   DEFAULT_RESET_PC : default program counter after reset
//   PC_STEP          : sequential PC increment (one 32-bit word)
//   word_align()     : clears the two low address bits of a redirect target
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    SQUASH = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_hold_buffer.sv
// fetch_hold_buffer: one-entry skid register that parks a fetched word and
// its PC+4 while the pipeline is stalled.
//   clk, rst   : clock, asynchronous active-high reset
//   i_load     : capture i_word / i_pc4 and mark the entry valid
//   i_clear    : discard the entry (redirect)
//   i_consume  : entry has been delivered downstream, mark it empty
//   o_word, o_pc4, o_valid : current entry contents
module fetch_hold_buffer
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_clear,
  input  logic        i_consume,
  input  logic [31:0] i_word,
  input  logic [31:0] i_pc4,
  output logic [31:0] o_word,
  output logic [31:0] o_pc4,
  output logic        o_valid
);

  logic [31:0] r_word;
  logic [31:0] r_pc4;
  logic        r_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word  <= NOP_WORD;
      r_pc4   <= '0;
      r_valid <= 1'b0;
    end else if (i_clear) begin
      r_word  <= NOP_WORD;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_word  <= i_word;
      r_pc4   <= i_pc4;
      r_valid <= 1'b1;
    end else if (i_consume) begin
      r_valid <= 1'b0;
    end
  end

  assign o_word  = r_word;
  assign o_pc4   = r_pc4;
  assign o_valid = r_valid;

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: IF stage. Owns the PC, issues word reads to instruction
// memory over a req/ready handshake, and presents instruction / PC+4 (or a
// NOP bubble) plus the IF/ID write enable every cycle.
//   clock, startin          : clock, asynchronous active-high reset
//   pc_write                : hazard unit advance (0 = stall IF and IF/ID)
//   branch_taken/_target    : branch redirect request and destination
//   jump/jump_target        : jump redirect request and destination
//   imem_addr/req/ready/rdata : instruction memory handshake
//   instruction_out, pc_plus_4_out, if_id_write, fetch_valid : to IF/ID
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clock,
  input  logic        startin,
  input  logic        pc_write,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction_out,
  output logic [31:0] pc_plus_4_out,
  output logic        if_id_write,
  output logic        fetch_valid
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_redirect_pc;

  logic         w_redirect;
  logic [31:0]  w_target;
  logic [31:0]  w_pc_plus_4;
  logic         w_buf_load;
  logic         w_buf_clear;
  logic         w_buf_consume;
  logic [31:0]  w_buf_word;
  logic [31:0]  w_buf_pc4;
  logic         w_buf_valid;

  assign w_redirect  = branch_taken | jump;
  assign w_target    = word_align(branch_taken ? branch_target : jump_target);
  assign w_pc_plus_4 = r_pc + PC_STEP;

  assign w_buf_load    = (r_state == FETCH) && !w_redirect && imem_ready && !pc_write;
  assign w_buf_clear   = (r_state == HOLD) && w_redirect;
  assign w_buf_consume = (r_state == HOLD) && !w_redirect && pc_write;

  fetch_hold_buffer u_hold (
    .clk       (clock),
    .rst       (startin),
    .i_load    (w_buf_load),
    .i_clear   (w_buf_clear),
    .i_consume (w_buf_consume),
    .i_word    (imem_rdata),
    .i_pc4     (w_pc_plus_4),
    .o_word    (w_buf_word),
    .o_pc4     (w_buf_pc4),
    .o_valid   (w_buf_valid)
  );

  always_ff @(posedge clock or posedge startin) begin
    if (startin) begin
      r_state       <= FETCH;
      r_pc          <= RESET_PC;
      r_redirect_pc <= RESET_PC;
    end else begin
      case (r_state)
        FETCH: begin
          if (w_redirect) begin
            if (imem_ready) begin
              r_pc <= w_target;
            end else begin
              r_redirect_pc <= w_target;
              r_state       <= SQUASH;
            end
          end else if (imem_ready) begin
            r_pc <= w_pc_plus_4;
            if (!pc_write) r_state <= HOLD;
          end
        end
        HOLD: begin
          if (w_redirect) begin
            r_pc    <= w_target;
            r_state <= FETCH;
          end else if (pc_write) begin
            r_state <= FETCH;
          end
        end
        SQUASH: begin
          // The outstanding fetch must complete before the PC may move; a
          // redirect arriving in the completing cycle takes precedence.
          if (imem_ready) begin
            r_pc    <= w_redirect ? w_target : r_redirect_pc;
            r_state <= FETCH;
          end else if (w_redirect) begin
            r_redirect_pc <= w_target;
          end
        end
        default: r_state <= FETCH;
      endcase
    end
  end

  always_comb begin
    imem_req        = 1'b0;
    imem_addr       = r_pc;
    instruction_out = NOP_WORD;
    pc_plus_4_out   = w_pc_plus_4;
    fetch_valid     = 1'b0;
    if_id_write     = pc_write | w_redirect;
    if (startin) begin
      imem_addr     = RESET_PC;
      pc_plus_4_out = RESET_PC + PC_STEP;
      if_id_write   = 1'b0;
    end else begin
      case (r_state)
        FETCH: begin
          imem_req = 1'b1;
          if (!w_redirect && imem_ready && pc_write) begin
            instruction_out = imem_rdata;
            fetch_valid     = 1'b1;
          end
        end
        HOLD: begin
          if (w_buf_consume) begin
            instruction_out = w_buf_word;
            pc_plus_4_out   = w_buf_pc4;
            fetch_valid     = w_buf_valid;
          end
        end
        SQUASH: imem_req = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  logic        clock = 1'b0;
  logic        startin = 1'b1;
  logic        pc_write = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = '0;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instruction_out;
  logic [31:0] pc_plus_4_out;
  logic        if_id_write;
  logic        fetch_valid;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // {imem_req, imem_addr, instruction_out, pc_plus_4_out, fetch_valid, if_id_write}
  logic [98:0] obs;
  logic [98:0] exp_v;
  assign obs = {imem_req, imem_addr, instruction_out, pc_plus_4_out, fetch_valid, if_id_write};

  always #5 clock = ~clock;

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clock           (clock),
    .startin         (startin),
    .pc_write        (pc_write),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .jump            (jump),
    .jump_target     (jump_target),
    .imem_addr       (imem_addr),
    .imem_req        (imem_req),
    .imem_ready      (imem_ready),
    .imem_rdata      (imem_rdata),
    .instruction_out (instruction_out),
    .pc_plus_4_out   (pc_plus_4_out),
    .if_id_write     (if_id_write),
    .fetch_valid     (fetch_valid)
  );

  task automatic cyc;
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic pw, input logic rdy, input logic [31:0] rd,
                       input logic br, input logic [31:0] bt,
                       input logic jp, input logic [31:0] jt);
    pc_write      = pw;
    imem_ready    = rdy;
    imem_rdata    = rd;
    branch_taken  = br;
    branch_target = bt;
    jump          = jp;
    jump_target   = jt;
  endtask

  task automatic do_reset;
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    startin = 1'b1;
    cyc();
    startin = 1'b0;
  endtask

  task automatic test_reset;
    startin = 1'b1;
    drive(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h40, 1'b0, '0);
    #1;
    exp_v = {1'b0, 32'h0, 32'h0, 32'h4, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset_outputs: got %h expected %h", obs, exp_v); end
    cyc();
    startin = 1'b0;
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    #1;
    exp_v = {1'b1, 32'h0, 32'h0, 32'h4, 1'b0, 1'b1};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset_release: got %h expected %h", obs, exp_v); end
    cyc();
  endtask

  task automatic test_zero_wait;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 32'h1000_0000 + 32'(i), 1'b0, '0, 1'b0, '0);
      #1;
      exp_v = {1'b1, 32'(4 * i), 32'h1000_0000 + 32'(i), 32'(4 * i + 4), 1'b1, 1'b1};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL zero_wait_%0d: got %h expected %h", i, obs, exp_v); end
      cyc();
    end
  endtask

  task automatic test_latency;
    do_reset();
    drive(1'b1, 1'b0, 32'h1234_5678, 1'b0, '0, 1'b0, '0);
    #1;
    exp_v = {1'b1, 32'h0, 32'h0, 32'h4, 1'b0, 1'b1};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL latency_wait: got %h expected %h", obs, exp_v); end
    cyc();
    drive(1'b1, 1'b1, 32'h1111_0001, 1'b0, '0, 1'b0, '0);
    #1;
    exp_v = {1'b1, 32'h0, 32'h1111_0001, 32'h4, 1'b1, 1'b1};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL latency_word: got %h expected %h", obs, exp_v); end
    cyc();
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    #1;
    exp_v = {1'b1, 32'h4, 32'h0, 32'h8, 1'b0, 1'b1};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL latency_next_addr: got %h expected %h", obs, exp_v); end
    cyc();
  endtask

  task automatic test_hold;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 32'hAAAA_0000, 1'b0, '0, 1'b0, '0);
      cyc();
    end
    drive(1'b0, 1'b1, 32'h2002_0005, 1'b0, '0, 1'b0, '0);
    #1;
    exp_v = {1'b1, 32'h8, 32'h0, 32'hC, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL hold_capture: got %h expected %h", obs, exp_v); end
    cyc();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 32'hBAD0_0000, 1'b0, '0, 1'b0, '0);
      #1;
      exp_v = {1'b0, 32'hC, 32'h0, 32'h10, 1'b0, 1'b0};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL hold_stall_%0d: got %h expected %h", i, obs, exp_v); end
      cyc();
    end
    drive(1'b1, 1'b1, 32'hBAD0_0001, 1'b0, '0, 1'b0, '0);
    #1;
    exp_v = {1'b0, 32'hC, 32'h2002_0005, 32'hC, 1'b1, 1'b1};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL hold_release: got %h expected %h", obs, exp_v); end
    cyc();
    drive(1'b1, 1'b1, 32'h3333_0003, 1'b0, '0, 1'b0, '0);
    #1;
    exp_v = {1'b1, 32'hC, 32'h3333_0003, 32'h10, 1'b1, 1'b1};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL hold_resume: got %h expected %h", obs, exp_v); end
    cyc();
  endtask

  task automatic test_squash;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 32'h5555_0000, 1'b0, '0, 1'b0, '0);
      cyc();
    end
    drive(1'b0, 1'b0, '0, 1'b1, 32'h40, 1'b0, '0);
    #1;
    exp_v = {1'b1, 32'h10, 32'h0, 32'h14, 1'b0, 1'b1};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL squash_redirect: got %h expected %h", obs, exp_v); end
    cyc();
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    #1;
    exp_v = {1'b1, 32'h10, 32'h0, 32'h14, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL squash_wait: got %h expected %h", obs, exp_v); end
    cyc();
    drive(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, '0, 1'b0, '0);
    #1;
    exp_v = {1'b1, 32'h10, 32'h0, 32'h14, 1'b0, 1'b1};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL squash_discard: got %h expected %h", obs, exp_v); end
    cyc();
    drive(1'b1, 1'b1, 32'h4040_4040, 1'b0, '0, 1'b0, '0);
    #1;
    exp_v = {1'b1, 32'h40, 32'h4040_4040, 32'h44, 1'b1, 1'b1};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL squash_target: got %h expected %h", obs, exp_v); end
    cyc();
  endtask

  task automatic test_squash_retarget;
    do_reset();
    drive(1'b1, 1'b0, '0, 1'b1, 32'h40, 1'b0, '0);
    cyc();
    drive(1'b0, 1'b1, 32'hDEAD_0001, 1'b0, '0, 1'b1, 32'h100);
    #1;
    exp_v = {1'b1, 32'h0, 32'h0, 32'h4, 1'b0, 1'b1};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL retarget_cycle: got %h expected %h", obs, exp_v); end
    cyc();
    drive(1'b1, 1'b1, 32'h0100_0100, 1'b0, '0, 1'b0, '0);
    #1;
    exp_v = {1'b1, 32'h100, 32'h0100_0100, 32'h104, 1'b1, 1'b1};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL retarget_addr: got %h expected %h", obs, exp_v); end
    cyc();
  endtask

  task automatic test_priority;
    do_reset();
    drive(1'b1, 1'b1, 32'h7777_0000, 1'b1, 32'h80, 1'b1, 32'hC0);
    #1;
    exp_v = {1'b1, 32'h0, 32'h0, 32'h4, 1'b0, 1'b1};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL prio_redirect: got %h expected %h", obs, exp_v); end
    cyc();
    drive(1'b1, 1'b1, 32'h7777_0001, 1'b0, '0, 1'b1, 32'h0D);
    #1;
    exp_v = {1'b1, 32'h80, 32'h0, 32'h84, 1'b0, 1'b1};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL prio_branch_wins: got %h expected %h", obs, exp_v); end
    cyc();
    drive(1'b1, 1'b1, 32'h7777_0002, 1'b0, '0, 1'b0, '0);
    #1;
    exp_v = {1'b1, 32'hC, 32'h7777_0002, 32'h10, 1'b1, 1'b1};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL prio_jump_align: got %h expected %h", obs, exp_v); end
    cyc();
  endtask

  task automatic test_wrap;
    do_reset();
    drive(1'b1, 1'b1, '0, 1'b0, '0, 1'b1, 32'hFFFF_FFFE);
    cyc();
    drive(1'b1, 1'b1, 32'h9999_9999, 1'b0, '0, 1'b0, '0);
    #1;
    exp_v = {1'b1, 32'hFFFF_FFFC, 32'h9999_9999, 32'h0, 1'b1, 1'b1};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL wrap_last: got %h expected %h", obs, exp_v); end
    cyc();
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    #1;
    exp_v = {1'b1, 32'h0, 32'h0, 32'h4, 1'b0, 1'b1};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL wrap_zero: got %h expected %h", obs, exp_v); end
    cyc();
  endtask

  task automatic test_reset_midwait;
    do_reset();
    drive(1'b1, 1'b1, 32'h6666_0000, 1'b0, '0, 1'b0, '0);
    cyc();
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    cyc();
    startin = 1'b1;
    #1;
    exp_v = {1'b0, 32'h0, 32'h0, 32'h4, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL midwait_reset: got %h expected %h", obs, exp_v); end
    cyc();
    startin = 1'b0;
    #1;
    exp_v = {1'b1, 32'h0, 32'h0, 32'h4, 1'b0, 1'b1};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL midwait_release: got %h expected %h", obs, exp_v); end
    cyc();
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_latency();
    test_hold();
    test_squash();
    test_squash_retarget();
    test_priority();
    test_wrap();
    test_reset_midwait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
